// File: rtl/fpu_bus_core.sv
// fpu_bus_core: single-precision (binary32) coprocessor behind an 8-bit CPU bus.
//
// The host writes operands A and B one byte at a time. It then writes an opcode,
// which starts the operation. It waits for cmd_end, reads the 32-bit result R
// one byte at a time, and finally pulses end_ack.
//
// Register map (bytes are little-endian):
//   0x0-0x3  A[7:0]..A[31:24]   read/write (writes are dropped while busy)
//   0x4-0x7  B[7:0]..B[31:24]   read/write (writes are dropped while busy)
//   0x8      command            write-only (dropped while busy or cmd_end)
//   0x9-0xC  R[7:0]..R[31:24]   read-only
//   other    writes ignored, reads return 0x00
//
// Opcodes:
//   00 add, 01 sub, 02 mul (only when FPU_MUL_EN is defined),
//   10 pi, 11 pi/2, 12 e, 13 one, 14 zero, anything else gives a quiet NaN.
//
// Optional feature:
//   `define FPU_MUL_EN builds the 24x24 multiplier path. Without it, opcode 02
//   is treated as an unknown opcode.
//
// Ports:
//   clk          system clock, rising edge
//   arst         asynchronous reset, active low
//   databus_in   write data
//   databus_out  read data; 0x00 unless cs=0 and rd=0
//   addr         register select
//   cs, rd, wr   bus strobes, active low
//   end_ack      host acknowledge of cmd_end, active high
//   cmd_end      command finished / irq, held until acknowledged
//   busy         high while an operation is in flight
module fpu_bus_core (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] databus_in,
  output logic [7:0] databus_out,
  input  logic [3:0] addr,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic       end_ack,
  output logic       cmd_end,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADDSUB = 3'd3;
  localparam logic [2:0] S_MUL    = 3'd4;
  localparam logic [2:0] S_NORM   = 3'd5;
  localparam logic [2:0] S_ROUND  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
`ifdef FPU_MUL_EN
  localparam logic [7:0] OP_MUL = 8'h02;
`endif

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  logic [31:0]       a_r, b_r, r_r, res_r;
  logic [7:0]        op_r;
  logic [2:0]        state;
  logic              busy_r, cmd_end_r, wr_q;

  // Datapath working registers.
  logic              s_r;       // result sign
  logic              sub_r;     // effective subtraction
  logic signed [9:0] exp_r;     // working exponent, wide enough for mul and underflow
  logic [26:0]       big_m;     // larger operand as {1.m, G, R, S}
  logic [23:0]       sml_m;     // smaller operand mantissa, before alignment
  logic [7:0]        diff_r;    // exponent difference
  logic [26:0]       sml_al;    // aligned smaller mantissa, with G/R/S
  logic [27:0]       sum_r;     // bit 27 is the carry position
  logic [26:0]       norm_m;
  logic              zero_r;

  assign busy    = busy_r;
  assign cmd_end = cmd_end_r;

  // A write happens once per wr strobe: on the first edge where wr is seen low.
  logic wr_stb;
  assign wr_stb = !cs && !wr && wr_q;

  // ---------------- operand decode ----------------
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic [23:0] ma, mb;
  logic        sb_eff, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;

  always_comb begin
    ea     = a_r[30:23];
    eb     = b_r[30:23];
    fa     = a_r[22:0];
    fb     = b_r[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    // Denormal inputs are flushed to zero.
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    ma     = a_zero ? 24'd0 : {1'b1, fa};
    mb     = b_zero ? 24'd0 : {1'b1, fb};
    sb_eff = b_r[31] ^ (op_r == OP_SUB);
    a_ge   = {ea, ma} >= {eb, mb};
  end

  // ---------------- align: shift right with sticky ----------------
  logic [50:0] al_wide;
  logic [26:0] al_out;

  always_comb begin
    al_wide = {sml_m, 27'd0} >> diff_r;
    // Beyond 26 places only the sticky bit is left.
    if (diff_r > 8'd26) al_out = {26'd0, |sml_m};
    else                al_out = {al_wide[50:25], |al_wide[24:0]};
  end

  // ---------------- normalize: leading-zero count ----------------
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  logic [4:0]  lz;
  logic [26:0] norm_sh;
  assign lz      = lzc27(sum_r[26:0]);
  assign norm_sh = sum_r[26:0] << lz;

  // ---------------- round to nearest even and pack ----------------
  logic              rnd_up;
  logic [24:0]       mant25;
  logic signed [9:0] exp_rnd;
  logic [31:0]       rnd_res;

  always_comb begin
    rnd_up  = norm_m[2] & (norm_m[3] | norm_m[1] | norm_m[0]);
    mant25  = {1'b0, norm_m[26:3]} + {24'd0, rnd_up};
    exp_rnd = mant25[24] ? exp_r + 10'sd1 : exp_r;
    if (zero_r)                     rnd_res = 32'd0;
    else if (exp_rnd >= 10'sd255)   rnd_res = {s_r, PINF[30:0]};
    else if (exp_rnd <= 10'sd0)     rnd_res = {s_r, 31'd0};
    else                            rnd_res = {s_r, exp_rnd[7:0],
                                               mant25[24] ? mant25[23:1] : mant25[22:0]};
  end

`ifdef FPU_MUL_EN
  logic [47:0] prod;
  assign prod = big_m[26:3] * sml_m;
`endif

  // ---------------- control and datapath ----------------
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      r_r       <= 32'd0;
      res_r     <= 32'd0;
      op_r      <= 8'd0;
      state     <= S_IDLE;
      busy_r    <= 1'b0;
      cmd_end_r <= 1'b0;
      wr_q      <= 1'b1;
      s_r       <= 1'b0;
      sub_r     <= 1'b0;
      exp_r     <= 10'sd0;
      big_m     <= 27'd0;
      sml_m     <= 24'd0;
      diff_r    <= 8'd0;
      sml_al    <= 27'd0;
      sum_r     <= 28'd0;
      norm_m    <= 27'd0;
      zero_r    <= 1'b0;
    end else begin
      wr_q <= wr;
      if (cmd_end_r && end_ack) cmd_end_r <= 1'b0;

      case (state)
        S_UNPACK: begin
          state <= S_DONE;
          case (op_r)
            OP_ADD, OP_SUB: begin
              if (a_nan || b_nan)     res_r <= QNAN;
              else if (a_inf && b_inf) res_r <= (a_r[31] != sb_eff) ? QNAN : {a_r[31], PINF[30:0]};
              else if (a_inf)          res_r <= {a_r[31], PINF[30:0]};
              else if (b_inf)          res_r <= {sb_eff, PINF[30:0]};
              else begin
                state <= S_ALIGN;
                sub_r <= a_r[31] ^ sb_eff;
                if (a_ge) begin
                  s_r    <= a_r[31];
                  exp_r  <= $signed({2'b00, ea});
                  big_m  <= {ma, 3'b000};
                  sml_m  <= mb;
                  diff_r <= ea - eb;
                end else begin
                  s_r    <= sb_eff;
                  exp_r  <= $signed({2'b00, eb});
                  big_m  <= {mb, 3'b000};
                  sml_m  <= ma;
                  diff_r <= eb - ea;
                end
              end
            end
`ifdef FPU_MUL_EN
            OP_MUL: begin
              if (a_nan || b_nan)                             res_r <= QNAN;
              else if ((a_inf && b_zero) || (b_inf && a_zero)) res_r <= QNAN;
              else if (a_inf || b_inf)                        res_r <= {a_r[31] ^ b_r[31], PINF[30:0]};
              else if (a_zero || b_zero)                      res_r <= 32'd0;
              else begin
                state <= S_MUL;
                s_r   <= a_r[31] ^ b_r[31];
                exp_r <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                big_m <= {ma, 3'b000};
                sml_m <= mb;
              end
            end
`endif
            8'h10:   res_r <= 32'h40490FDB;
            8'h11:   res_r <= 32'h3FC90FDB;
            8'h12:   res_r <= 32'h402DF854;
            8'h13:   res_r <= 32'h3F800000;
            8'h14:   res_r <= 32'h00000000;
            default: res_r <= QNAN;
          endcase
        end
        S_ALIGN: begin
          sml_al <= al_out;
          state  <= S_ADDSUB;
        end
        S_ADDSUB: begin
          // big >= small in magnitude, so a subtraction never goes negative.
          sum_r <= sub_r ? {1'b0, big_m} - {1'b0, sml_al}
                         : {1'b0, big_m} + {1'b0, sml_al};
          state <= S_NORM;
        end
        S_MUL: begin
`ifdef FPU_MUL_EN
          // The product of two 1.x values is in [1,4): bit 46 or 47 leads.
          sum_r <= {prod[47:21], |prod[20:0]};
          state <= S_NORM;
`else
          state <= S_IDLE;
`endif
        end
        S_NORM: begin
          zero_r <= (sum_r == 28'd0);
          if (sum_r[27]) begin
            norm_m <= {sum_r[27:2], sum_r[1] | sum_r[0]};
            exp_r  <= exp_r + 10'sd1;
          end else begin
            norm_m <= norm_sh;
            exp_r  <= exp_r - $signed({5'd0, lz});
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          res_r <= rnd_res;
          state <= S_DONE;
        end
        S_DONE: begin
          r_r       <= res_r;
          busy_r    <= 1'b0;
          cmd_end_r <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (wr_stb) begin
        case (addr)
          4'h0, 4'h1, 4'h2, 4'h3:
            if (!busy_r) a_r[8*addr[1:0] +: 8] <= databus_in;
          4'h4, 4'h5, 4'h6, 4'h7:
            if (!busy_r) b_r[8*addr[1:0] +: 8] <= databus_in;
          4'h8:
            if (!busy_r && !cmd_end_r) begin
              op_r   <= databus_in;
              state  <= S_UNPACK;
              busy_r <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    databus_out = 8'h00;
    if (!cs && !rd) begin
      case (addr)
        4'h0: databus_out = a_r[7:0];
        4'h1: databus_out = a_r[15:8];
        4'h2: databus_out = a_r[23:16];
        4'h3: databus_out = a_r[31:24];
        4'h4: databus_out = b_r[7:0];
        4'h5: databus_out = b_r[15:8];
        4'h6: databus_out = b_r[23:16];
        4'h7: databus_out = b_r[31:24];
        4'h9: databus_out = r_r[7:0];
        4'hA: databus_out = r_r[15:8];
        4'hB: databus_out = r_r[23:16];
        4'hC: databus_out = r_r[31:24];
        default: databus_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_bus_core.sv
// Directed bench for fpu_bus_core. Every command that should produce a result
// pushes its expected value onto a queue. When cmd_end is seen, the bench reads
// R and compares it against the value popped from the queue.
module tb_fpu_bus_core;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic [7:0] databus_in = 8'h00;
  logic [7:0] databus_out;
  logic [3:0] addr = 4'h0;
  logic       cs = 1'b1, rd = 1'b1, wr = 1'b1, end_ack = 1'b0;
  logic       cmd_end, busy;

  fpu_bus_core dut (
    .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(databus_out),
    .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack),
    .cmd_end(cmd_end), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

`ifdef FPU_MUL_EN
  localparam logic [31:0] MUL_EXP = 32'h40400000;
`else
  localparam logic [31:0] MUL_EXP = 32'h7FC00000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    wr = 1'b1; cs = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; cs = 1'b0; rd = 1'b0;
    #1 d = databus_out;
    rd = 1'b1; cs = 1'b1;
  endtask

  task automatic read_r(output logic [31:0] r);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      bus_rd(4'(9 + i), b);
      r[8*i +: 8] = b;
    end
  endtask

  task automatic load_ab(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) bus_wr(4'(i), a[8*i +: 8]);
    for (int i = 0; i < 4; i++) bus_wr(4'(4 + i), b[8*i +: 8]);
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] expv);
    exp_q.push_back(expv);
    bus_wr(4'h8, op);
  endtask

  // Returns the number of falling edges waited after the command write.
  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!cmd_end && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic collect(input string tag);
    logic [31:0] r;
    read_r(r);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, r);
    end else begin
      check(tag, r, exp_q.pop_front());
    end
  endtask

  task automatic ack(input string tag);
    @(negedge clk); end_ack = 1'b1;
    @(negedge clk); end_ack = 1'b0;
    check({tag, "_ack"}, {31'd0, cmd_end}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] expv);
    int n;
    issue(op, expv);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(12, n);
    check({tag, "_done"}, {31'd0, cmd_end}, 32'd1);
    check({tag, "_lat"}, {31'd0, n <= 8}, 32'd1);
    collect(tag);
    ack(tag);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] r;
    int          n;

    repeat (3) @(negedge clk);
    arst = 1'b1;

    // Reset state
    read_r(r);
    check("rst_R", r, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_end", {31'd0, cmd_end}, 32'd0);
    bus_rd(4'hF, b);
    check("rst_unmapped", {24'd0, b}, 32'd0);

    // Mixed-sign add
    load_ab(32'h43A9AB64, 32'hC479FFF0);
    run_op("add_mixed", 8'h00, 32'hC4252A3E);

    // 1.5 and 2.25
    load_ab(32'h3FC00000, 32'h40100000);
    run_op("add_simple", 8'h00, 32'h40700000);
    run_op("sub_simple", 8'h01, 32'hBF400000);
    load_ab(32'h40100000, 32'h40100000);
    run_op("sub_zero", 8'h01, 32'h00000000);

    // Rounding ties and cancellation
    load_ab(32'h3F800000, 32'h33800000);
    run_op("rne_tie_even", 8'h00, 32'h3F800000);
    load_ab(32'h3F800000, 32'h33800001);
    run_op("rne_above", 8'h00, 32'h3F800001);
    load_ab(32'h3F800000, 32'h3F7FFFFF);
    run_op("sub_cancel", 8'h01, 32'h33800000);

    // Constant latency, then a second command that must be ignored
    issue(8'h11, 32'h3FC90FDB);
    wait_done(3, n);
    check("k_piby2_lat", {31'd0, cmd_end}, 32'd1);
    collect("k_piby2");
    bus_wr(4'h8, 8'h10);
    repeat (4) @(negedge clk);
    check("ignored_cmd_end", {31'd0, cmd_end}, 32'd1);
    check("ignored_busy", {31'd0, busy}, 32'd0);
    read_r(r);
    check("ignored_R", r, 32'h3FC90FDB);
    ack("k_piby2");

    run_op("k_e", 8'h12, 32'h402DF854);
    run_op("k_bad", 8'h3C, 32'h7FC00000);

    // Edge cases
    load_ab(32'h7F7FFFFF, 32'h7F7FFFFF);
    run_op("ovf", 8'h00, 32'h7F800000);
    load_ab(32'h7F800000, 32'h7F800000);
    run_op("inf_minus_inf", 8'h01, 32'h7FC00000);
    load_ab(32'h7FC00000, 32'h7F800000);
    run_op("nan_in", 8'h00, 32'h7FC00000);
    load_ab(32'hFF800000, 32'h3F800000);
    run_op("inf_plus_fin", 8'h00, 32'hFF800000);

    // Multiply (the result depends on whether the feature is built)
    load_ab(32'h3FC00000, 32'h40000000);
    run_op("mul", 8'h02, MUL_EXP);

    // Reset while cmd_end is held
    bus_wr(4'h8, 8'h13);
    wait_done(3, n);
    check("pre_rst_cmd_end", {31'd0, cmd_end}, 32'd1);
    @(negedge clk); arst = 1'b0;
    #1;
    check("arst_cmd_end", {31'd0, cmd_end}, 32'd0);
    read_r(r);
    check("arst_R", r, 32'h0);
    @(negedge clk); arst = 1'b1;

    // Reset in the middle of an add
    load_ab(32'h3FC00000, 32'h40100000);
    bus_wr(4'h8, 8'h00);
    check("mid_busy", {31'd0, busy}, 32'd1);
    arst = 1'b0;
    #1;
    check("mid_arst_busy", {31'd0, busy}, 32'd0);
    check("mid_arst_cmd_end", {31'd0, cmd_end}, 32'd0);
    @(negedge clk); arst = 1'b1;
    repeat (10) @(negedge clk);
    check("discarded_cmd_end", {31'd0, cmd_end}, 32'd0);
    read_r(r);
    check("discarded_R", r, 32'h0);
    bus_rd(4'h3, b);
    check("rst_A_byte", {24'd0, b}, 32'd0);

    // Recovery after reset
    load_ab(32'h3FC00000, 32'h40100000);
    run_op("post_rst_add", 8'h00, 32'h40700000);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
